// File: rtl/rstx_02a_if.sv
// rstx_02a_if: transmit-side bus between the queueing logic and the UART
// transmitter rstx_02a.
//   txParallelData  data word to queue (DATA_BITS wide)
//   txTrigger       write strobe, one write per cycle while high
//   txSerialData    serial line, idles high
//   txStatus        FIFO non-empty or frame in flight
//   txFull          FIFO full
//   txLevel         FIFO occupancy (LVL_W wide)
//   txOverrun       one-cycle pulse per dropped write
// The master drives data/strobe; the slave (transmitter) drives the rest.
interface rstx_02a_if #(
  parameter int DATA_BITS = 8,
  parameter int LVL_W     = 3
);
  logic [DATA_BITS-1:0] txParallelData;
  logic                 txTrigger;
  logic                 txSerialData;
  logic                 txStatus;
  logic                 txFull;
  logic [LVL_W-1:0]     txLevel;
  logic                 txOverrun;

  modport master (
    output txParallelData, txTrigger,
    input  txSerialData, txStatus, txFull, txLevel, txOverrun
  );

  modport slave (
    input  txParallelData, txTrigger,
    output txSerialData, txStatus, txFull, txLevel, txOverrun
  );
endinterface

// File: rtl/rstx_02a.sv
// rstx_02a: single-clock UART transmitter with internal baud divider,
// configurable frame format and a small transmit FIFO. Queued words are sent
// back-to-back with no idle gap between the last stop bit and the next start.
// Ports:
//   F25Clk  system clock (only clock)
//   reset   asynchronous, active-high reset
//   tx      rstx_02a_if.slave: write data/strobe in; line, status, full,
//           level and overrun out (all outputs registered)
module rstx_02a #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        F25Clk,
  input  logic        reset,
  rstx_02a_if.slave   tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (CLK_DIV >= 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_BITS >= 2) ? $clog2(DATA_BITS) : 1;

  // Elaboration-time parameter legality checks
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("rstx_02a: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("rstx_02a: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("rstx_02a: STOP_BITS must be 1 or 2");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("rstx_02a: CLK_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rstx_02a: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  // Odd mode: bit set when data has an even number of ones; even mode: odd.
  function automatic logic par_calc(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      par_calc = ~^d;
    end else begin
      par_calc = ^d;
    end
  endfunction

  // Registers
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   line_q, line_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   full_q, status_q, ovr_q;

  logic                   wr_s;
  logic                   pop_s;
  logic                   wrap_s;
  logic                   fifo_ne_s;
  logic                   status_d;
  logic                   full_d;
  logic [DATA_BITS-1:0]   head_s;

  // A write is judged on the pre-edge full flag, so a pop in the same cycle
  // does not make room for it.
  assign wr_s      = tx.txTrigger & ~full_q;
  assign wrap_s    = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign fifo_ne_s = (level_q != {LVL_W{1'b0}});
  assign head_s    = mem_q[rptr_q];

  // FSM next-state, line value and pop decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    line_d  = line_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        cnt_d  = {CNT_W{1'b0}};
        if (fifo_ne_s) begin
          pop_s   = 1'b1;
          shreg_d = head_s;
          par_d   = par_calc(head_s);
          line_d  = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (wrap_s) begin
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {BIT_W{1'b0}};
          line_d  = shreg_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (wrap_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (idx_q == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              line_d  = par_q;
              state_d = ST_PAR;
            end else begin
              line_d  = 1'b1;
              stop_d  = 1'b0;
              state_d = ST_STOP;
            end
          end else begin
            // Shift so the next bit to send is always at position 0.
            idx_d   = idx_q + BIT_W'(1);
            shreg_d = shreg_q >> 1;
            line_d  = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PAR: begin
        if (wrap_s) begin
          cnt_d   = {CNT_W{1'b0}};
          line_d  = 1'b1;
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (wrap_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (stop_q == 1'(STOP_BITS - 1)) begin
            if (fifo_ne_s) begin
              // Gapless: next start bit begins on the final stop edge.
              pop_s   = 1'b1;
              shreg_d = head_s;
              par_d   = par_calc(head_s);
              line_d  = 1'b0;
              state_d = ST_START;
            end else begin
              line_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        line_d  = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy and registered status flags
  always_comb begin
    case ({wr_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d   = (level_d == LVL_W'(FIFO_DEPTH));
    status_d = (level_d != {LVL_W{1'b0}}) || (state_d != ST_IDLE);
  end

  // FSM, shifter and line register
  always_ff @(posedge F25Clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {BIT_W{1'b0}};
      stop_q  <= 1'b0;
      shreg_q <= {DATA_BITS{1'b0}};
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      line_q  <= line_d;
    end
  end

  // FIFO pointers and status/overrun flags
  always_ff @(posedge F25Clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= {PTR_W{1'b0}};
      rptr_q   <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      full_q   <= 1'b0;
      status_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_s) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      level_q  <= level_d;
      full_q   <= full_d;
      status_q <= status_d;
      ovr_q    <= tx.txTrigger & full_q;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge F25Clk) begin
    if (wr_s) begin
      mem_q[wptr_q] <= tx.txParallelData;
    end
  end

  assign tx.txSerialData = line_q;
  assign tx.txStatus     = status_q;
  assign tx.txFull       = full_q;
  assign tx.txLevel      = level_q;
  assign tx.txOverrun    = ovr_q;

endmodule

// File: tb/tb_rstx_02a.sv
// tb_rstx_02a: directed bench for rstx_02a. Three instances cover 8N1,
// 8 data / odd parity / 2 stop, and 7 data / even parity / 1 stop, all with
// CLK_DIV=4 and FIFO_DEPTH=4. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_rstx_02a;
  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rstx_02a_if #(.DATA_BITS(8), .LVL_W(3)) ifa ();
  rstx_02a_if #(.DATA_BITS(8), .LVL_W(3)) ifb ();
  rstx_02a_if #(.DATA_BITS(7), .LVL_W(3)) ifc ();

  rstx_02a #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_DIV(DIV), .FIFO_DEPTH(4))
    u_dut_a (.F25Clk(clk), .reset(rst), .tx(ifa));
  rstx_02a #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CLK_DIV(DIV), .FIFO_DEPTH(4))
    u_dut_b (.F25Clk(clk), .reset(rst), .tx(ifb));
  rstx_02a #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .CLK_DIV(DIV), .FIFO_DEPTH(4))
    u_dut_c (.F25Clk(clk), .reset(rst), .tx(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input int d);
    case (d)
      0:       return ifa.txSerialData;
      1:       return ifb.txSerialData;
      default: return ifc.txSerialData;
    endcase
  endfunction

  function automatic logic status_of(input int d);
    case (d)
      0:       return ifa.txStatus;
      1:       return ifb.txStatus;
      default: return ifc.txStatus;
    endcase
  endfunction

  task automatic set_trig(input int d, input logic t, input logic [7:0] v);
    case (d)
      0: begin ifa.txTrigger = t; ifa.txParallelData = v; end
      1: begin ifb.txTrigger = t; ifb.txParallelData = v; end
      default: begin ifc.txTrigger = t; ifc.txParallelData = v[6:0]; end
    endcase
  endtask

  // One write strobe; called just after a falling edge, returns just after the
  // falling edge that follows the write edge.
  task automatic do_write(input int d, input logic [7:0] v);
    set_trig(d, 1'b1, v);
    @(negedge clk);
    set_trig(d, 1'b0, 8'h00);
  endtask

  // Called one cycle before the start bit; checks every cycle of the frame.
  task automatic check_frame(input int d, input logic [7:0] v, input int nb,
                             input int has_par, input logic pbit, input int sb,
                             input string nm);
    logic bits_q[$];
    bits_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits_q.push_back(v[i]);
    if (has_par != 0) bits_q.push_back(pbit);
    for (int i = 0; i < sb; i++) bits_q.push_back(1'b1);
    for (int b = 0; b < bits_q.size(); b++) begin
      for (int k = 0; k < DIV; k++) begin
        @(negedge clk);
        check($sformatf("%s_bit%0d_c%0d", nm, b, k), 32'(line_of(d)), 32'(bits_q[b]));
        if (k == 0) check($sformatf("%s_status_bit%0d", nm, b), 32'(status_of(d)), 32'd1);
      end
    end
  endtask

  task automatic check_idle(input int d, input string nm);
    @(negedge clk);
    check({nm, "_idle_line"}, 32'(line_of(d)), 32'd1);
    check({nm, "_idle_status"}, 32'(status_of(d)), 32'd0);
  endtask

  initial begin
    logic [2:0] lvl_exp [7];
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_trig(0, 1'b0, 8'h00);
    set_trig(1, 1'b0, 8'h00);
    set_trig(2, 1'b0, 8'h00);
    #1;
    check("rst_line_a", 32'(ifa.txSerialData), 32'd1);
    check("rst_status_a", 32'(ifa.txStatus), 32'd0);
    check("rst_full_a", 32'(ifa.txFull), 32'd0);
    check("rst_level_a", 32'(ifa.txLevel), 32'd0);
    check("rst_ovr_a", 32'(ifa.txOverrun), 32'd0);
    check("rst_line_b", 32'(ifb.txSerialData), 32'd1);
    check("rst_line_c", 32'(ifc.txSerialData), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, 0x55: start bit one cycle after the write edge, 40-cycle frame
    do_write(0, 8'h55);
    check("t1_level", 32'(ifa.txLevel), 32'd1);
    check("t1_status_early", 32'(ifa.txStatus), 32'd1);
    check("t1_line_pre", 32'(ifa.txSerialData), 32'd1);
    check_frame(0, 8'h55, 8, 0, 1'b0, 1, "t1");
    check_idle(0, "t1");

    // Odd parity, 2 stop bits: 0x55 -> parity 1, 0x07 -> parity 0
    do_write(1, 8'h55);
    check_frame(1, 8'h55, 8, 1, 1'b1, 2, "t2a");
    check_idle(1, "t2a");
    do_write(1, 8'h07);
    check_frame(1, 8'h07, 8, 1, 1'b0, 2, "t2b");
    check_idle(1, "t2b");

    // 7 data bits, even parity: 0x41 -> 1,0,0,0,0,0,1 then parity 0
    do_write(2, 8'h41);
    check_frame(2, 8'h41, 7, 1, 1'b0, 1, "t3");
    check_idle(2, "t3");

    // Back-to-back writes, simultaneous write/pop, full and overrun
    lvl_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    set_trig(0, 1'b1, 8'hA0);
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          check($sformatf("t4_level_%0d", i), 32'(ifa.txLevel), 32'(lvl_exp[i]));
          check($sformatf("t4_full_%0d", i), 32'(ifa.txFull), (i >= 4) ? 32'd1 : 32'd0);
          check($sformatf("t4_ovr_%0d", i), 32'(ifa.txOverrun), (i == 5) ? 32'd1 : 32'd0);
          if (i < 5) set_trig(0, 1'b1, 8'hA1 + 8'(i));
          else set_trig(0, 1'b0, 8'h00);
        end
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
          check_frame(0, 8'hA0 + 8'(f), 8, 0, 1'b0, 1, $sformatf("t4_f%0d", f));
        end
      end
    join
    check_idle(0, "t4");
    check("t4_level_end", 32'(ifa.txLevel), 32'd0);

    // Reset during data bit 3 with two bytes still queued
    set_trig(0, 1'b1, 8'hF7);
    @(negedge clk);
    set_trig(0, 1'b1, 8'h11);
    @(negedge clk);
    set_trig(0, 1'b1, 8'h22);
    @(negedge clk);
    set_trig(0, 1'b0, 8'h00);
    check("t5_level_queued", 32'(ifa.txLevel), 32'd2);
    repeat (16) @(negedge clk);
    check("t5_line_bit3", 32'(ifa.txSerialData), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_line", 32'(ifa.txSerialData), 32'd1);
    check("t5_rst_level", 32'(ifa.txLevel), 32'd0);
    check("t5_rst_status", 32'(ifa.txStatus), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("t5_post_line_%0d", i), 32'(ifa.txSerialData), 32'd1);
    end
    check("t5_post_status", 32'(ifa.txStatus), 32'd0);
    check("t5_post_level", 32'(ifa.txLevel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
